// File: rtl/temp_seg_display_if.sv
// Display-stage bus: raw DS18B20 word in, conversion status and 7-segment outputs back.
// The master side drives the temperature word; the slave side is the display converter.
interface temp_seg_display_if;
    logic [15:0] temp_raw;
    logic        temp_valid;
    logic        busy;
    logic        bcd_valid;
    logic        sign;
    logic [1:0]  hundreds;
    logic        select;
    logic [6:0]  seven_segment_out;

    modport master (
        output temp_raw, temp_valid,
        input  busy, bcd_valid, sign, hundreds, select, seven_segment_out
    );

    modport slave (
        input  temp_raw, temp_valid,
        output busy, bcd_valid, sign, hundreds, select, seven_segment_out
    );
endinterface

// File: rtl/temp_seg_display.sv
// DS18B20 word -> sign/magnitude -> sequential double-dabble BCD -> multiplexed 7-segment display.
// Define DS_ROUND_EN to round the magnitude half away from zero instead of truncating toward zero.
module temp_seg_display #(
    parameter int CLK_FREQ_HZ = 27_000_000,
    parameter int REFRESH_HZ  = 1_000
) (
    input logic               clk,
    input logic               rst,
    temp_seg_display_if.slave bus
);

    localparam int HALF_RAW = CLK_FREQ_HZ / (2 * REFRESH_HZ);
    localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
    localparam int CW       = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t        state_q, state_d;
    logic [15:0]   word_q;
    logic          pend_q;
    logic [15:0]   pend_word_q;
    logic [7:0]    bin_q;
    logic [11:0]   bcd_q;
    logic [2:0]    bit_q;
    logic          neg_q;
    logic          sign_q;
    logic [1:0]    hund_q;
    logic [3:0]    tens_q;
    logic [3:0]    units_q;
    logic          shown_q;
    logic [CW-1:0] cnt_q;
    logic          sel_q;

    logic [15:0]   abs16;
    logic [7:0]    mag;
    logic          neg;
    logic [11:0]   bcdAdj;
    logic [19:0]   shifted;
    logic [6:0]    seg;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

`ifdef DS_ROUND_EN
    logic [15:0] rnd16;
    always_comb begin
        abs16 = word_q[15] ? (~word_q + 16'd1) : word_q;
        rnd16 = (abs16 + 16'd8) >> 4;
        mag   = (rnd16 > 16'd199) ? 8'd199 : rnd16[7:0];
        neg   = word_q[15] & (mag != 8'd0);
    end
`else
    always_comb begin
        abs16 = word_q[15] ? (~word_q + 16'd1) : word_q;
        mag   = (abs16[11:4] > 8'd199) ? 8'd199 : abs16[11:4];
        neg   = word_q[15] & (mag != 8'd0);
    end
`endif

    // One double-dabble step: correct each BCD nibble, then shift binary bits into the BCD field.
    always_comb begin
        bcdAdj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcdAdj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
        shifted = {bcdAdj, bin_q} << 1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.temp_valid || pend_q) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (bit_q == 3'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // A strobe arriving while busy parks in pending; an IDLE strobe supersedes whatever is parked.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q      <= 16'h0000;
            pend_q      <= 1'b0;
            pend_word_q <= 16'h0000;
            bin_q       <= 8'h00;
            bcd_q       <= 12'h000;
            bit_q       <= 3'd0;
            neg_q       <= 1'b0;
            sign_q      <= 1'b0;
            hund_q      <= 2'd0;
            tens_q      <= 4'd0;
            units_q     <= 4'd0;
            shown_q     <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                if (bus.temp_valid) begin
                    word_q <= bus.temp_raw;
                    pend_q <= 1'b0;
                end else if (pend_q) begin
                    word_q <= pend_word_q;
                    pend_q <= 1'b0;
                end
            end else if (bus.temp_valid) begin
                pend_q      <= 1'b1;
                pend_word_q <= bus.temp_raw;
            end
            case (state_q)
                LOAD: begin
                    bin_q <= mag;
                    bcd_q <= 12'h000;
                    neg_q <= neg;
                    bit_q <= 3'd7;
                end
                SHIFT: begin
                    bcd_q <= shifted[19:8];
                    bin_q <= shifted[7:0];
                    bit_q <= bit_q - 3'd1;
                end
                DONE: begin
                    sign_q  <= neg_q;
                    hund_q  <= 2'(bcd_q[11:8]);
                    tens_q  <= bcd_q[7:4];
                    units_q <= bcd_q[3:0];
                    shown_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            sel_q <= 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            sel_q <= ~sel_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Tens digit is blanked when it would be a leading zero.
    always_comb begin
        seg = 7'h00;
        if (shown_q) begin
            if (!sel_q)                                seg = seg7(units_q);
            else if (tens_q != 4'd0 || hund_q != 2'd0) seg = seg7(tens_q);
        end
    end

    assign bus.busy              = (state_q != IDLE);
    assign bus.bcd_valid         = (state_q == DONE);
    assign bus.sign              = sign_q;
    assign bus.hundreds          = hund_q;
    assign bus.select            = sel_q;
    assign bus.seven_segment_out = seg;

endmodule

// File: tb/tb_temp_seg_display.sv
// Self-checking bench for temp_seg_display: directed and randomized readings against a degree-level model.
// Honours DS_ROUND_EN in the model so the same bench covers both builds.
module tb_temp_seg_display;

    localparam int CLK_HZ = 27_000_000;
    localparam int REF_HZ = CLK_HZ / 8;
    localparam logic [6:0] SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    typedef struct {
        bit neg;
        int hund;
        int tens;
        int units;
    } exp_t;

    logic clk;
    logic rst;
    int   checkCount;
    int   passCount;

    temp_seg_display_if dif ();

    temp_seg_display #(
        .CLK_FREQ_HZ (CLK_HZ),
        .REFRESH_HZ  (REF_HZ)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Temperature in degrees from the signed sixteenths, then decimal digits.
    function automatic exp_t modelOf(input logic [15:0] w);
        exp_t e;
        int v, a, m;
        v = int'($signed(w));
        a = (v < 0) ? -v : v;
`ifdef DS_ROUND_EN
        m = (a + 8) / 16;
`else
        m = a / 16;
`endif
        if (m > 199) m = 199;
        e.neg   = (v < 0) && (m != 0);
        e.hund  = m / 100;
        e.tens  = (m / 10) % 10;
        e.units = m % 10;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic [15:0] w);
        @(negedge clk);
        dif.temp_raw   = w;
        dif.temp_valid = 1'b1;
        @(negedge clk);
        dif.temp_valid = 1'b0;
    endtask

    task automatic waitSelect(input logic want, input string tag);
        int n;
        n = 0;
        while (dif.select !== want && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) checkOutput({tag, "_sel_timeout"}, 32'(dif.select), 32'(want));
    endtask

    task automatic checkDisplay(input logic [15:0] w, input string tag);
        exp_t e;
        logic [6:0] tensSeg;
        e = modelOf(w);
        tensSeg = (e.tens == 0 && e.hund == 0) ? 7'h00 : SEG[e.tens];
        checkOutput({tag, "_sign"}, 32'(dif.sign), 32'(e.neg));
        checkOutput({tag, "_hundreds"}, 32'(dif.hundreds), 32'(e.hund));
        waitSelect(1'b0, tag);
        checkOutput({tag, "_units_seg"}, 32'(dif.seven_segment_out), 32'(SEG[e.units]));
        waitSelect(1'b1, tag);
        checkOutput({tag, "_tens_seg"}, 32'(dif.seven_segment_out), 32'(tensSeg));
    endtask

    task automatic runConversion(input logic [15:0] w, input string tag);
        int lat;
        applyStimulus(w);
        checkOutput({tag, "_busy"}, 32'(dif.busy), 32'd1);
        lat = 1;
        while (dif.bcd_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'd10);
        @(negedge clk);
        checkOutput({tag, "_bcd_valid_pulse"}, 32'(dif.bcd_valid), 32'd0);
        checkDisplay(w, tag);
    endtask

    // First strobe 0x0191 at cycle 0, two more at tB / tC (tC < 0 means none).
    task automatic pendingScenario(input logic [15:0] wB, input int tB, input logic [15:0] wC,
                                   input int tC, input string tag);
        int pulses, first, second;
        logic [15:0] latest;
        pulses = 0;
        first  = -1;
        second = -1;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (dif.bcd_valid === 1'b1) begin
                pulses++;
                if (pulses == 1) first = c;
                else if (pulses == 2) second = c;
            end
            dif.temp_valid = 1'b0;
            if (c == 0) begin
                dif.temp_raw = 16'h0191; dif.temp_valid = 1'b1;
            end else if (c == tB) begin
                dif.temp_raw = wB; dif.temp_valid = 1'b1;
            end else if (c == tC) begin
                dif.temp_raw = wC; dif.temp_valid = 1'b1;
            end
        end
        dif.temp_valid = 1'b0;
        latest = (tC >= 0) ? wC : wB;
        checkOutput({tag, "_pulses"}, 32'(pulses), 32'd2);
        checkOutput({tag, "_first_at"}, 32'(first), 32'd10);
        checkOutput({tag, "_second_at"}, 32'(second), 32'd21);
        checkDisplay(latest, tag);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, 32'(dif.busy), 32'd0);
        checkOutput({tag, "_bcd_valid"}, 32'(dif.bcd_valid), 32'd0);
        checkOutput({tag, "_sign"}, 32'(dif.sign), 32'd0);
        checkOutput({tag, "_hundreds"}, 32'(dif.hundreds), 32'd0);
        checkOutput({tag, "_select"}, 32'(dif.select), 32'd0);
        checkOutput({tag, "_seg"}, 32'(dif.seven_segment_out), 32'd0);
    endtask

    initial begin
        int pulses, segSeen, r;
        logic [15:0] w;
        checkCount     = 0;
        passCount      = 0;
        rst            = 1'b0;
        dif.temp_raw   = 16'h0000;
        dif.temp_valid = 1'b0;

        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b1;

        // Refresh mux with HALF=4, and a blank display before any reading.
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checkOutput($sformatf("select_k%0d", k), 32'(dif.select), 32'((k / 4) % 2));
            checkOutput($sformatf("blank_k%0d", k), 32'(dif.seven_segment_out), 32'd0);
        end

        runConversion(16'h0191, "p25");
        runConversion(16'hFC90, "m55");
        runConversion(16'h07D0, "p125");
        runConversion(16'hFFF8, "m0p5");
        runConversion(16'h0000, "zero");
        runConversion(16'h0FFF, "sat255");
        runConversion(16'h0C80, "sat200");
        runConversion(16'h0008, "p0p5");

        for (int i = 0; i < 8; i++) begin
            r = int'($urandom_range(2880, 0)) - 880;
            w = 16'(r);
            runConversion(w, $sformatf("rand%0d_%04h", i, w));
        end

        pendingScenario(16'h0550, 3, 16'h0050, 8, "pend_latest");
        pendingScenario(16'hFE6F, 10, 16'h0000, -1, "pend_done_cycle");

        // Reset during SHIFT aborts the conversion and blanks the display.
        applyStimulus(16'h07D0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checkResetOutputs("midreset");
        @(negedge clk);
        rst = 1'b1;
        pulses  = 0;
        segSeen = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (dif.bcd_valid === 1'b1) pulses++;
            if (dif.seven_segment_out !== 7'h00) segSeen++;
        end
        checkOutput("midreset_no_pulse", 32'(pulses), 32'd0);
        checkOutput("midreset_stay_blank", 32'(segSeen), 32'd0);
        runConversion(16'hFF5E, "after_reset");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
